// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified data synchroniser with round-robin drain onto a valid/ready port.
// Event-to-valid latency NUM_STAGES+2 cycles; output register holds while out_valid && !out_ready.
module data_sync_mc #(
    parameter int WIDTH       = 8,
    parameter int NUM_CH      = 4,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = 0,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       en_pulse,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH-1:0]       overrun,
    input  logic                    ovr_clr
);

    logic [NUM_CH-1:0] sync_q [NUM_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [WIDTH-1:0]  hold_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   och_q, och_d;
    logic [WIDTH-1:0]  odata_q, odata_d;
    logic              ovld_q, ovld_d;

    logic [NUM_CH-1:0] sync_last;
    logic [NUM_CH-1:0] det;
    logic [NUM_CH-1:0] gnt_vec;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic              load_slot;

    assign sync_last = sync_q[NUM_STAGES-1];
    assign det       = (TOGGLE_MODE != 0) ? (sync_last ^ prev_q) : (sync_last & ~prev_q);
    assign load_slot = !ovld_q || out_ready;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_vec   = '0;
        idx       = 0;
        if (load_slot) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(ptr_q) + k) % NUM_CH;
                if (!gnt_found && pend_q[idx]) begin
                    gnt_found    = 1'b1;
                    gnt_idx      = CH_W'(idx);
                    gnt_vec[idx] = 1'b1;
                end
            end
        end
    end

    // A capture on the channel being granted re-arms pend and is not an overrun.
    always_comb begin
        pend_d = (pend_q & ~gnt_vec) | det;
        ovr_d  = (ovr_clr ? '0 : ovr_q) | (det & pend_q & ~gnt_vec);
    end

    always_comb begin
        ptr_d   = ptr_q;
        och_d   = och_q;
        odata_d = odata_q;
        ovld_d  = ovld_q;
        if (load_slot) begin
            if (gnt_found) begin
                odata_d = hold_q[gnt_idx];
                och_d   = gnt_idx;
                ovld_d  = 1'b1;
                ptr_d   = gnt_idx;
            end else begin
                ovld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= ch_en;
            for (int k = 1; k < NUM_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= sync_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (det[c]) hold_q[c] <= ch_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            pulse_q <= '0;
            ovr_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            och_q   <= '0;
            odata_q <= '0;
            ovld_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            pulse_q <= det;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
            och_q   <= och_d;
            odata_q <= odata_d;
            ovld_q  <= ovld_d;
        end
    end

    assign en_pulse  = pulse_q;
    assign out_data  = odata_q;
    assign out_ch    = och_q;
    assign out_valid = ovld_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench: dut0 runs rising-edge mode, dut1 runs toggle mode; both share clock and reset.
module tb_data_sync_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en, ch_en_t;
    logic [31:0] ch_data, ch_data_t;
    logic        out_ready, out_ready_t;
    logic        ovr_clr, ovr_clr_t;
    logic [3:0]  en_pulse, en_pulse_t;
    logic [7:0]  out_data, out_data_t;
    logic [1:0]  out_ch, out_ch_t;
    logic        out_valid, out_valid_t;
    logic [3:0]  overrun, overrun_t;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_sync_mc #(.WIDTH(8), .NUM_CH(4), .NUM_STAGES(2), .TOGGLE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ch_en(ch_en), .ch_data(ch_data), .en_pulse(en_pulse),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    data_sync_mc #(.WIDTH(8), .NUM_CH(4), .NUM_STAGES(2), .TOGGLE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ch_en(ch_en_t), .ch_data(ch_data_t), .en_pulse(en_pulse_t),
        .out_data(out_data_t), .out_ch(out_ch_t), .out_valid(out_valid_t), .out_ready(out_ready_t),
        .overrun(overrun_t), .ovr_clr(ovr_clr_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        ch_en = 4'h0;
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        n_total++;
        if ({out_valid, out_data, out_ch, en_pulse, overrun} !== 19'h0)
            $display("FAIL reset_dut0: got v=%0b d=%h ch=%0d p=%b o=%b want all 0", out_valid, out_data, out_ch, en_pulse, overrun);
        else n_pass++;
        n_total++;
        if ({out_valid_t, out_data_t, out_ch_t, en_pulse_t, overrun_t} !== 19'h0)
            $display("FAIL reset_dut1: got v=%0b d=%h ch=%0d p=%b o=%b want all 0", out_valid_t, out_data_t, out_ch_t, en_pulse_t, overrun_t);
        else n_pass++;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        ch_data[7:0] = 8'hA5;
        ch_en = 4'b0001;
        ticks(2);
        n_total++;
        if (en_pulse !== 4'b0000) $display("FAIL lat_early_pulse: got %b want 0000", en_pulse); else n_pass++;
        tick();
        n_total++;
        if (en_pulse !== 4'b0001 || out_valid !== 1'b0)
            $display("FAIL lat_pulse: got p=%b v=%0b want p=0001 v=0", en_pulse, out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (en_pulse !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd0)
            $display("FAIL lat_beat: got p=%b v=%0b d=%h ch=%0d want p=0000 v=1 d=a5 ch=0", en_pulse, out_valid, out_data, out_ch);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL lat_drop: got v=%0b want 0", out_valid); else n_pass++;
        ch_en = 4'h0;
        ticks(4);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [4];
        logic [7:0] exp_d [4];
        do_reset();
        out_ready = 1'b1;
        ch_data = 32'h44332211;
        ch_en = 4'hF;
        ticks(3);
        n_total++;
        if (en_pulse !== 4'hF) $display("FAIL rr_pulse_all: got %b want 1111", en_pulse); else n_pass++;
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[k] || out_data !== exp_d[k])
                $display("FAIL rr1_beat%0d: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h", k, out_valid, out_ch, out_data, exp_ch[k], exp_d[k]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rr1_end: got v=%0b want 0", out_valid); else n_pass++;
        ch_en = 4'h0;
        ticks(4);
        ch_en = 4'b0010;
        ticks(4);
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22)
            $display("FAIL rr_ptr1: got v=%0b ch=%0d d=%h want v=1 ch=1 d=22", out_valid, out_ch, out_data);
        else n_pass++;
        ch_en = 4'h0;
        ticks(5);
        ch_data = 32'h88776655;
        ch_en = 4'hF;
        ticks(3);
        exp_ch = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_d  = '{8'h77, 8'h88, 8'h55, 8'h66};
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[k] || out_data !== exp_d[k])
                $display("FAIL rr2_beat%0d: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h", k, out_valid, out_ch, out_data, exp_ch[k], exp_d[k]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rr2_end: got v=%0b want 0", out_valid); else n_pass++;
        ch_en = 4'h0;
        ticks(4);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        ch_data[7:0] = 8'h5A;
        ch_en = 4'b0001;
        ticks(4);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0)
            $display("FAIL bp_first: got v=%0b d=%h ch=%0d want v=1 d=5a ch=0", out_valid, out_data, out_ch);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0)
                $display("FAIL bp_hold%0d: got v=%0b d=%h ch=%0d want v=1 d=5a ch=0", i, out_valid, out_data, out_ch);
            else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL bp_release: got v=%0b want 0", out_valid); else n_pass++;
        ch_en = 4'h0;
        ticks(4);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        ch_data[7:0] = 8'h77;
        ch_en = 4'b0001;
        ticks(4);
        ch_data[15:8] = 8'h10;
        ch_en = 4'b0011;
        ticks(3);
        n_total++;
        if (en_pulse !== 4'b0010 || overrun !== 4'b0000)
            $display("FAIL ovr_first_evt: got p=%b o=%b want p=0010 o=0000", en_pulse, overrun);
        else n_pass++;
        ch_en = 4'b0001;
        ticks(4);
        ch_data[15:8] = 8'h20;
        ch_en = 4'b0011;
        ticks(3);
        n_total++;
        if (overrun !== 4'b0010 || out_data !== 8'h77 || out_ch !== 2'd0)
            $display("FAIL ovr_set: got o=%b d=%h ch=%0d want o=0010 d=77 ch=0", overrun, out_data, out_ch);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h20)
            $display("FAIL ovr_newest: got v=%0b ch=%0d d=%h want v=1 ch=1 d=20", out_valid, out_ch, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL ovr_single_beat: got v=%0b want 0", out_valid); else n_pass++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_total++;
        if (overrun !== 4'b0000) $display("FAIL ovr_clear: got %b want 0000", overrun); else n_pass++;
        ch_en = 4'h0;
        out_ready = 1'b0;
        ticks(4);
        ch_data[15:0] = 16'h3077;
        ch_en = 4'b0011;
        ticks(4);
        ch_en = 4'b0001;
        ticks(4);
        ch_data[15:8] = 8'h31;
        ch_en = 4'b0011;
        ticks(2);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_total++;
        if (overrun !== 4'b0010) $display("FAIL ovr_set_beats_clr: got %b want 0010", overrun); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h31)
            $display("FAIL ovr_second_beat: got v=%0b ch=%0d d=%h want v=1 ch=1 d=31", out_valid, out_ch, out_data);
        else n_pass++;
        ch_en = 4'h0;
        ticks(4);
    endtask

    task automatic test_reset_mid();
        logic stale;
        do_reset();
        out_ready = 1'b0;
        ch_data[23:0] = 24'h030201;
        ch_en = 4'b0111;
        ticks(4);
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h01)
            $display("FAIL rmid_pre: got v=%0b ch=%0d d=%h want v=1 ch=0 d=01", out_valid, out_ch, out_data);
        else n_pass++;
        rst = 1'b0;
        ch_en = 4'h0;
        #1;
        n_total++;
        if ({out_valid, out_data, out_ch, en_pulse, overrun} !== 19'h0)
            $display("FAIL rmid_async: got v=%0b d=%h ch=%0d p=%b o=%b want all 0", out_valid, out_data, out_ch, en_pulse, overrun);
        else n_pass++;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0 || en_pulse !== 4'h0) stale = 1'b1;
        end
        n_total++;
        if (stale !== 1'b0) $display("FAIL rmid_stale: got stale=%0b want 0", stale); else n_pass++;
        ch_data = 32'hC3000000 | 32'h0000009C;
        ch_en = 4'b1001;
        ticks(4);
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h9C)
            $display("FAIL rmid_ch0_first: got v=%0b ch=%0d d=%h want v=1 ch=0 d=9c", out_valid, out_ch, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'hC3)
            $display("FAIL rmid_ch3_next: got v=%0b ch=%0d d=%h want v=1 ch=3 d=c3", out_valid, out_ch, out_data);
        else n_pass++;
        ch_en = 4'h0;
        ticks(4);
    endtask

    task automatic test_toggle();
        logic seen;
        out_ready_t = 1'b1;
        ch_data_t[23:16] = 8'h01;
        ch_en_t[2] = 1'b1;
        ticks(3);
        n_total++;
        if (en_pulse_t !== 4'b0100) $display("FAIL tog_rise_pulse: got %b want 0100", en_pulse_t); else n_pass++;
        tick();
        n_total++;
        if (en_pulse_t !== 4'b0000 || out_valid_t !== 1'b1 || out_ch_t !== 2'd2 || out_data_t !== 8'h01)
            $display("FAIL tog_rise_beat: got p=%b v=%0b ch=%0d d=%h want p=0000 v=1 ch=2 d=01", en_pulse_t, out_valid_t, out_ch_t, out_data_t);
        else n_pass++;
        ticks(4);
        ch_data_t[23:16] = 8'h02;
        ch_en_t[2] = 1'b0;
        ticks(3);
        n_total++;
        if (en_pulse_t !== 4'b0100) $display("FAIL tog_fall_pulse: got %b want 0100", en_pulse_t); else n_pass++;
        tick();
        n_total++;
        if (out_valid_t !== 1'b1 || out_ch_t !== 2'd2 || out_data_t !== 8'h02)
            $display("FAIL tog_fall_beat: got v=%0b ch=%0d d=%h want v=1 ch=2 d=02", out_valid_t, out_ch_t, out_data_t);
        else n_pass++;
        ticks(4);
        ch_en_t[2] = 1'b1;
        #2;
        ch_en_t[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (en_pulse_t !== 4'h0 || out_valid_t !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL tog_glitch: got event=%0b want 0", seen); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        ch_en = 4'h0;
        ch_en_t = 4'h0;
        ch_data = 32'h0;
        ch_data_t = 32'h0;
        out_ready = 1'b1;
        out_ready_t = 1'b1;
        ovr_clr = 1'b0;
        ovr_clr_t = 1'b0;
        ticks(2);
        test_reset();
        rst = 1'b1;
        test_latency();
        test_round_robin();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_toggle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
- Multi-channel, parametrised successor to the single-bus enable-qualified data synchroniser.
- Each channel synchronises its own enable into the clk domain through a NUM_STAGES flop chain and detects an event, either a rising edge or any toggle.
- On each event the channel captures its data bus into a per-channel hold register.
- A round-robin arbiter drains pending captures onto one valid/ready output port.
- Sticky per-channel overrun flags report captures lost to backpressure.

Parameters:
- WIDTH, 8: data width per channel.
- NUM_CH, 4: number of channels (>=1).
- NUM_STAGES, 2: synchroniser depth (>=2).
- TOGGLE_MODE, 0: event type. 0 = rising edge of synchronised ch_en; 1 = any edge (toggle protocol).
- CH_W, max(1, clog2(NUM_CH)): channel index width (derived).

Ports:
- clk  in  1  destination clock
- rst  in  1  reset, asynchronous, active-low
- ch_en  in  NUM_CH  unsynchronised enables, one per channel
- ch_data  in  NUM_CH*WIDTH  unsynchronised data; channel i at [i*WIDTH +: WIDTH]; source holds it stable from before ch_en changes until after capture
- en_pulse  out  NUM_CH  one-cycle strobe per channel on capture
- out_data  out  WIDTH  captured data of the granted channel
- out_ch  out  CH_W  index of the granted channel
- out_valid  out  1  output holds valid data
- out_ready  in  1  consumer accepts when out_valid && out_ready
- overrun  out  NUM_CH  sticky: a capture overwrote unconsumed data
- ovr_clr  in  1  synchronous clear of all overrun bits

Behaviour:
- Reset: everything is 0 while rst is low, asynchronously. This covers the sync chains, edge register, hold registers, pend, en_pulse, out_data, out_ch, out_valid and overrun. The round-robin pointer resets to NUM_CH-1, so channel 0 has first priority.
- Sync chain per channel: stage 0 samples ch_en; the last stage feeds the edge register prev.
- Event detection, combinational from the last stage s and prev:
  - TOGGLE_MODE=0: det = s & ~prev.
  - TOGGLE_MODE=1: det = s ^ prev.
- Capture, on a clock edge with det[i]=1:
  - hold[i] <= ch_data slice i.
  - pend[i] <= 1.
  - en_pulse[i] <= 1 for exactly one cycle; en_pulse is 0 otherwise.
- Event latency: ch_en first sampled high at edge 1 gives en_pulse[i] and pend[i] high after edge NUM_STAGES+1.
- Output stage, a single register:
  - A load slot exists when out_valid=0, or when out_valid=1 and out_ready=1.
  - In a load slot with any pend bit set, grant the first pending channel searching from pointer+1, wrapping modulo NUM_CH.
  - On grant: out_data <= hold[g], out_ch <= g, out_valid <= 1, pend[g] <= 0, pointer <= g.
  - In a load slot with nothing pending, out_valid <= 0 if a transfer occurred.
  - Minimum latency: out_valid high after edge NUM_STAGES+2.
  - Back-to-back transfers run at one per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_ch are held stable.
- Simultaneous grant and new capture on the same channel: the output takes the old hold value; hold takes the new data; pend stays 1 (capture wins over clear); no overrun.
- Overrun:
  - det[i]=1 while pend[i]=1 and channel i is not granted that edge sets overrun[i] <= 1.
  - hold[i] is overwritten (newest wins). Only one pending event per channel is retained.
- ovr_clr=1 clears all overrun bits. A set on the same edge wins for that bit.
- Events on different channels in the same cycle are all captured independently.
- In TOGGLE_MODE=1, ch_en already high at reset release produces one event NUM_STAGES+1 edges later; this is by design. The same applies in mode 0.
- Reset mid-operation: pending data and any output beat are discarded; no partial state survives.

Test Plan:
1. Latency (NUM_STAGES=2, NUM_CH=4, TOGGLE_MODE=0, out_ready=1): ch_data[0]=8'hA5, ch_en[0] 0->1 before edge 1 -> en_pulse[0] high after edge 3 for one cycle; out_valid=1, out_data=8'hA5, out_ch=0 after edge 4, low after edge 5.
2. Round-robin: ch_en[3:0] 0->F together, data 11/22/33/44, out_ready=1 -> out_valid for 4 consecutive cycles with out_ch 0,1,2,3 and data 11,22,33,44. Repeat with pointer at 1 -> order 2,3,0,1.
3. Backpressure: out_ready=0 for 10 cycles after out_valid rises on ch0=8'h5A -> out_data stays 8'h5A, out_ch stays 0; one beat on out_ready=1, then out_valid=0.
4. Overrun: out_ready=0, two ch1 events (8'h10, then 8'h20) -> overrun[1]=1; after release a single beat 8'h20 on ch1. ovr_clr pulse -> overrun=0. ovr_clr on the same edge as a new overrun -> bit stays 1.
5. Toggle mode (TOGGLE_MODE=1): ch_en[2] 0->1->0 spaced 8 cycles, data 8'h01, 8'h02 -> two en_pulse[2] strobes and beats 8'h01, 8'h02; none for a 1-cycle glitch filtered out before the sync chain samples it.
6. Reset mid-operation: assert rst with pend=4'b0110 and out_valid=1 -> all outputs 0 immediately; after release no stale beats; the next event on ch0 is served first.
